// File: rtl/multi_debouncer.sv
// multi_debouncer: N independent debounce channels for board keys and switches.
// Each channel synchronises its raw pin, optionally inverts it, qualifies level
// changes over STABLE_CYCLES samples and produces a clean level plus
// single-cycle press, release and long-press pulses.
module multi_debouncer #(
    parameter int              N_CH          = 4,
    parameter int              STABLE_CYCLES = 50000,
    parameter int              LONG_CYCLES   = 50000000,
    parameter int              CNT_W         = 26,
    parameter logic [N_CH-1:0] INV_MASK      = {N_CH{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] long_press
);

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_CHK_HI = 2'd1,
        S_HIGH   = 2'd2,
        S_CHK_LO = 2'd3
    } state_t;

    // Counter constants, sized to the counter so every compare is width-matched.
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    // Value the counter parks at once long_press has been spent for this press.
    localparam logic [CNT_W-1:0] LONG_SAT    = CNT_W'(LONG_CYCLES);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi = gi + 1) begin : g_ch
            logic             sync1_q, sync1_d;
            logic             sync2_q, sync2_d;
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q,   cnt_d;
            logic             level_q, level_d;
            logic             rise_q,  rise_d;
            logic             fall_q,  fall_d;
            logic             long_q,  long_d;

            // Polarity is fixed before the synchroniser so the FSM only ever sees "pressed = 1".
            assign sync1_d = din[gi] ^ INV_MASK[gi];
            assign sync2_d = sync1_q;

            // Next-state logic: qualify level changes, count the hold time, and raise one-cycle pulses.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                level_d = level_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                long_d  = 1'b0;
                case (state_q)
                    S_LOW: begin
                        if (sync2_q) begin
                            state_d = S_CHK_HI;
                            cnt_d   = CNT_ONE;
                        end else begin
                            cnt_d   = CNT_ZERO;
                        end
                    end
                    S_CHK_HI: begin
                        if (!sync2_q) begin
                            // Bounce: drop the partial qualification without any pulse.
                            state_d = S_LOW;
                            cnt_d   = CNT_ZERO;
                        end else if (cnt_q == STABLE_LAST) begin
                            state_d = S_HIGH;
                            level_d = 1'b1;
                            rise_d  = 1'b1;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            cnt_d   = cnt_q + CNT_ONE;
                        end
                    end
                    S_HIGH: begin
                        if (!sync2_q) begin
                            state_d = S_CHK_LO;
                            cnt_d   = CNT_ONE;
                        end else if (cnt_q == LONG_LAST) begin
                            long_d  = 1'b1;
                            cnt_d   = LONG_SAT;
                        end else if (cnt_q < LONG_SAT) begin
                            cnt_d   = cnt_q + CNT_ONE;
                        end
                    end
                    S_CHK_LO: begin
                        if (sync2_q) begin
                            // Glitch during a hold: resume HIGH with the long-press already spent.
                            state_d = S_HIGH;
                            cnt_d   = LONG_SAT;
                        end else if (cnt_q == STABLE_LAST) begin
                            state_d = S_LOW;
                            level_d = 1'b0;
                            fall_d  = 1'b1;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            cnt_d   = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = S_LOW;
                        cnt_d   = CNT_ZERO;
                    end
                endcase
            end

            // Channel registers; reset discards any qualification or hold in progress.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    state_q <= S_LOW;
                    cnt_q   <= CNT_ZERO;
                    level_q <= 1'b0;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                    long_q  <= 1'b0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                    long_q  <= long_d;
                end
            end

            assign db_level[gi]   = level_q;
            assign rise_pulse[gi] = rise_q;
            assign fall_pulse[gi] = fall_q;
            assign long_press[gi] = long_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed checks of multi_debouncer with N_CH=4,
// STABLE_CYCLES=4, LONG_CYCLES=10, channel 2 active-low.
module tb_multi_debouncer;

    localparam int N_CH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N_CH-1:0] din = '0;
    logic [N_CH-1:0] db_level;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
    logic [N_CH-1:0] long_press;

    int checks = 0;
    int errors = 0;
    int rise_cnt [N_CH];
    int fall_cnt [N_CH];
    int long_cnt [N_CH];
    int both_cnt = 0;

    multi_debouncer #(
        .N_CH         (4),
        .STABLE_CYCLES(4),
        .LONG_CYCLES  (10),
        .CNT_W        (8),
        .INV_MASK     (4'b0100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .db_level  (db_level),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", tag, got, $time);
        end
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < N_CH; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
            long_cnt[i] = 0;
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge and tallying pulses.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_CH; i++) begin
                rise_cnt[i] += int'(rise_pulse[i]);
                fall_cnt[i] += int'(fall_pulse[i]);
                long_cnt[i] += int'(long_press[i]);
                if (rise_pulse[i] && fall_pulse[i]) both_cnt++;
            end
        end
    endtask

    initial begin
        logic [7:0] pat;
        clr_cnt();

        // Reset state
        #2 rst = 1'b1;
        #1;
        check_eq("reset_level", {28'd0, db_level}, 32'h0);
        check_eq("reset_pulses", {20'd0, rise_pulse, fall_pulse, long_press}, 32'h0);
        tick(2);
        rst = 1'b0;

        // All channels pressed (channel 2 is active-low, so its pin is 0)
        din = 4'b1011;
        tick(5);
        check_eq("press_all_e5_level", {28'd0, db_level}, 32'h0);
        tick(1);
        check_eq("press_all_e6_level", {28'd0, db_level}, 32'hF);
        check_eq("press_all_e6_rise", {28'd0, rise_pulse}, 32'hF);

        // Reset asserted mid-cycle while the rise pulse is high
        rst = 1'b1;
        #1;
        check_eq("async_rst_level", {28'd0, db_level}, 32'h0);
        check_eq("async_rst_rise", {28'd0, rise_pulse}, 32'h0);
        tick(1);
        rst = 1'b0;
        tick(5);
        check_eq("rerun_e5_level", {28'd0, db_level}, 32'h0);
        check_eq("rerun_e5_rise", {28'd0, rise_pulse}, 32'h0);
        tick(1);
        check_eq("rerun_e6_level", {28'd0, db_level}, 32'hF);
        check_eq("rerun_e6_rise", {28'd0, rise_pulse}, 32'hF);
        tick(1);
        check_eq("rerun_e7_rise", {28'd0, rise_pulse}, 32'h0);

        // Release all channels; channel 2 released means its pin is 1
        din = 4'b0100;
        tick(5);
        check_eq("release_all_e5_level", {28'd0, db_level}, 32'hF);
        check_eq("release_all_e5_fall", {28'd0, fall_pulse}, 32'h0);
        tick(1);
        check_eq("release_all_e6_level", {28'd0, db_level}, 32'h0);
        check_eq("release_all_e6_fall", {28'd0, fall_pulse}, 32'hF);

        // Clean press on channel 0 and long press timing
        din = 4'b0101;
        tick(5);
        check_eq("ch0_press_e5_level", {28'd0, db_level}, 32'h0);
        tick(1);
        check_eq("ch0_press_e6_level", {28'd0, db_level}, 32'h1);
        check_eq("ch0_press_e6_rise", {28'd0, rise_pulse}, 32'h1);
        clr_cnt();
        tick(9);
        check_eq("ch0_long_early", {28'd0, long_press}, 32'h0);
        check_eq("ch0_long_early_cnt", long_cnt[0], 32'd0);
        tick(1);
        check_eq("ch0_long_fire", {28'd0, long_press}, 32'h1);
        clr_cnt();
        tick(100);
        check_eq("ch0_no_second_long", long_cnt[0], 32'd0);
        check_eq("ch0_hold_no_rise", rise_cnt[0], 32'd0);
        check_eq("ch0_hold_no_fall", fall_cnt[0], 32'd0);
        check_eq("ch0_hold_level", {28'd0, db_level}, 32'h1);

        // Bounce on channel 1: values held two edges each, then settle at 0
        clr_cnt();
        pat = 8'b0011_0011;
        for (int k = 0; k < 8; k++) begin
            din[1] = pat[k];
            tick(1);
        end
        din[1] = 1'b0;
        tick(10);
        check_eq("ch1_bounce_rise", rise_cnt[1], 32'd0);
        check_eq("ch1_bounce_fall", fall_cnt[1], 32'd0);
        check_eq("ch1_bounce_level", {31'd0, db_level[1]}, 32'd0);
        din[1] = 1'b1;
        tick(8);
        check_eq("ch1_settle_rise", rise_cnt[1], 32'd1);
        check_eq("ch1_settle_level", {31'd0, db_level[1]}, 32'd1);

        // One-cycle release glitch on channel 0 after its long press
        clr_cnt();
        din[0] = 1'b0;
        tick(1);
        din[0] = 1'b1;
        tick(20);
        check_eq("ch0_glitch_fall", fall_cnt[0], 32'd0);
        check_eq("ch0_glitch_rise", rise_cnt[0], 32'd0);
        check_eq("ch0_glitch_long", long_cnt[0], 32'd0);
        check_eq("ch0_glitch_level", {31'd0, db_level[0]}, 32'd1);

        // True release on channel 0
        din[0] = 1'b0;
        tick(5);
        check_eq("ch0_release_e5_level", {31'd0, db_level[0]}, 32'd1);
        tick(1);
        check_eq("ch0_release_e6_fall", {28'd0, fall_pulse}, 32'h1);
        check_eq("ch0_release_e6_level", {31'd0, db_level[0]}, 32'd0);
        check_eq("ch1_single_long", long_cnt[1], 32'd1);

        // Polarity: channel 2 pin high reads as released, pin low as pressed
        check_eq("ch2_inv_idle", {31'd0, db_level[2]}, 32'd0);
        din = 4'b0010;
        tick(5);
        check_eq("ch2_press_e5_rise", {28'd0, rise_pulse}, 32'h0);
        tick(1);
        check_eq("ch2_press_e6_rise", {28'd0, rise_pulse}, 32'h4);
        check_eq("ch2_press_e6_level", {28'd0, db_level}, 32'h6);

        // Independence: channels 0 and 3 pressed while channel 1 released
        din = 4'b1001;
        tick(5);
        check_eq("indep_e5_pulses", {24'd0, rise_pulse, fall_pulse}, 32'h00);
        tick(1);
        check_eq("indep_e6_rise", {28'd0, rise_pulse}, 32'h9);
        check_eq("indep_e6_fall", {28'd0, fall_pulse}, 32'h2);
        check_eq("indep_e6_level", {28'd0, db_level}, 32'hD);
        tick(1);
        check_eq("indep_e7_pulses", {24'd0, rise_pulse, fall_pulse}, 32'h00);

        check_eq("rise_fall_exclusive", both_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
